// File: rtl/dmem_fill.sv
// dmem_fill: two-read/one-write data memory with a windowed fill sequencer.
// Define DMEM_FILL_RDREG_EN for registered reads with write-first forwarding.
module dmem_fill #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] FILL_VAL = DATA_W'(8'hA0),
  parameter int                INIT_LO  = 0,
  parameter int                INIT_HI  = 59
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              done,
  output logic              wr_drop
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LO  = ADDR_W'(INIT_LO);
  localparam logic [ADDR_W-1:0] HI  = ADDR_W'(INIT_HI);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              f_ok;
  logic              w_ok;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIM;
  endfunction

  // init wins over both the sweep write and a user write
  always_comb begin
    f_ok = (state == FILL) && !init;
    w_ok = (state == IDLE) && !init && wen && in_rng(waddr);
    we   = f_ok || w_ok;
    wa   = f_ok ? ptr : waddr;
    wd   = f_ok ? FILL_VAL : wdata;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa[IW-1:0]] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= LO;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_drop <= wen && !w_ok;
      unique case (state)
        IDLE: begin
          if (init) begin
            state <= FILL;
            ptr   <= LO;
            busy  <= 1'b1;
          end
        end
        FILL: begin
          if (init) begin
            ptr <= LO;
          end else if (ptr == HI) begin
            state <= IDLE;
            ptr   <= LO;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_FILL_RDREG_EN
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if (!in_rng(a)) return '0;
    if (we && wa == a) return wd;
    return mem[a[IW-1:0]];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      rdata0 <= rd(raddr0);
      rdata1 <= rd(raddr1);
    end
  end
`else
  assign rdata0 = in_rng(raddr0) ? mem[raddr0[IW-1:0]] : '0;
  assign rdata1 = in_rng(raddr1) ? mem[raddr1[IW-1:0]] : '0;
`endif

endmodule

// File: tb/tb_dmem_fill.sv
// tb_dmem_fill: random stimulus against a word-array model of dmem_fill.
// Covers both the combinational and DMEM_FILL_RDREG_EN read builds.
module tb_dmem_fill;

  localparam int N = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       init = 0, wen = 0;
  logic [7:0] waddr = 0, wdata = 0, raddr0 = 0, raddr1 = 0;
  logic [7:0] rdata0, rdata1;
  logic       busy, done, wr_drop;

  dmem_fill u0 (
    .clk(clk), .rst_n(rst_n), .init(init), .wen(wen),
    .waddr(waddr), .wdata(wdata), .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .done(done), .wr_drop(wr_drop)
  );

  logic        s_init = 0, s_wen = 0;
  logic [5:0]  s_waddr = 0, s_ra0 = 0, s_ra1 = 0;
  logic [15:0] s_wdata = 0, s_rd0, s_rd1;
  logic        s_busy, s_done, s_drop;

  dmem_fill #(
    .DATA_W(16), .ADDR_W(6), .DEPTH(48),
    .FILL_VAL(16'hBEEF), .INIT_LO(8), .INIT_HI(15)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .init(s_init), .wen(s_wen),
    .waddr(s_waddr), .wdata(s_wdata), .raddr0(s_ra0), .raddr1(s_ra1),
    .rdata0(s_rd0), .rdata1(s_rd1),
    .busy(s_busy), .done(s_done), .wr_drop(s_drop)
  );

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: word array, known flags, remaining fill words, next fill address
  logic [7:0] mm [256];
  bit         mk [256];
  int         left = 0, nxt = 0;
  bit         m_done = 0, m_drop = 0;
  int         busy_cnt = 0, done_cnt = 0, drop_cnt = 0;

  task automatic step(input bit i, input bit w, input logic [7:0] wa,
                      input logic [7:0] wd, input logic [7:0] r0,
                      input logic [7:0] r1);
    init = i; wen = w; waddr = wa; wdata = wd; raddr0 = r0; raddr1 = r1;
    #1;
`ifndef DMEM_FILL_RDREG_EN
    if (mk[r0]) check("rd0", 32'(rdata0), 32'(mm[r0]));
    if (mk[r1]) check("rd1", 32'(rdata1), 32'(mm[r1]));
`endif
    @(posedge clk);
    m_drop = w && (i || left > 0);
    if (i) begin
      left = N; nxt = 0; m_done = 0;
    end else if (left > 0) begin
      mm[nxt] = 8'hA0; mk[nxt] = 1; nxt++; left--;
      m_done = (left == 0);
    end else begin
      m_done = 0;
      if (w) begin mm[wa] = wd; mk[wa] = 1; end
    end
    @(negedge clk);
    check("busy", 32'(busy), 32'(left > 0));
    check("done", 32'(done), 32'(m_done));
    check("wr_drop", 32'(wr_drop), 32'(m_drop));
`ifdef DMEM_FILL_RDREG_EN
    if (mk[r0]) check("rd0q", 32'(rdata0), 32'(mm[r0]));
    if (mk[r1]) check("rd1q", 32'(rdata1), 32'(mm[r1]));
`endif
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    drop_cnt += int'(wr_drop);
  endtask

  task automatic idle();
    step(0, 0, 8'd0, 8'd0, 8'($urandom), 8'($urandom));
  endtask

  task automatic run_out();
    for (int k = 0; k < 200 && busy; k++) idle();
    if (busy) check("fill_timeout", 32'(busy), 32'd0);
  endtask

  int cnt;

  initial begin
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_drop", 32'(wr_drop), 32'd0);
    check("rst_sbusy", 32'(s_busy), 32'd0);
`ifdef DMEM_FILL_RDREG_EN
    check("rst_rd0", 32'(rdata0), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // small configuration
    s_init = 1;
    @(negedge clk);
    s_init = 0;
    cnt = 0;
    for (int k = 0; k < 50 && s_busy; k++) begin
      cnt++;
      @(negedge clk);
    end
    check("p_busy_cycles", 32'(cnt), 32'd8);
    for (int a = 8; a <= 15; a++) begin
      s_ra0 = 6'(a);
      s_ra1 = 6'd50;
      @(negedge clk);
      check("p_fill", 32'(s_rd0), 32'hBEEF);
    end
    check("p_oor_rd", 32'(s_rd1), 32'd0);
    s_wen = 1; s_waddr = 6'd50; s_wdata = 16'h1234;
    @(negedge clk);
    check("p_oor_drop", 32'(s_drop), 32'd1);
    s_wen = 0;
    @(negedge clk);
    check("p_drop_once", 32'(s_drop), 32'd0);

    // preload, then full sweep
    for (int a = 0; a < 64; a++)
      step(0, 1, 8'(a), (a == 60) ? 8'h3C : 8'($urandom), 8'($urandom),
           8'($urandom));
    busy_cnt = 0; done_cnt = 0;
    step(1, 0, 8'd0, 8'd0, 8'd0, 8'd1);
    run_out();
    check("sweep_busy", 32'(busy_cnt), 32'd60);
    check("sweep_done", 32'(done_cnt), 32'd1);
    for (int a = 0; a <= 60; a++) step(0, 0, 8'd0, 8'd0, 8'(a), 8'd60);
    check("addr60", 32'(rdata1), 32'h3C);

    // write/read incl. same-cycle read of the written word
    step(0, 1, 8'd61, 8'h5A, 8'd61, 8'd62);
    step(0, 1, 8'd62, 8'hC3, 8'd61, 8'd62);
    step(0, 0, 8'd0, 8'd0, 8'd61, 8'd62);
    check("wr61", 32'(rdata0), 32'h5A);
    check("wr62", 32'(rdata1), 32'hC3);

    // write attempt during fill
    drop_cnt = 0;
    step(1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 1; k < 200 && busy; k++) begin
      if (k == 5) step(0, 1, 8'd10, 8'hFF, 8'd10, 8'd11);
      else idle();
    end
    check("fill_wr_drops", 32'(drop_cnt), 32'd1);
    step(0, 0, 8'd0, 8'd0, 8'd10, 8'd10);
    check("mem10", 32'(rdata0), 32'hA0);

    // restart at fill cycle 20
    done_cnt = 0;
    step(1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 1; k < 20; k++) idle();
    busy_cnt = 0;
    step(1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_out();
    check("restart_busy", 32'(busy_cnt), 32'd60);
    check("restart_done", 32'(done_cnt), 32'd1);

    // init and wen together in IDLE
    drop_cnt = 0;
    step(1, 1, 8'd70, 8'h55, 8'd70, 8'd0);
    run_out();
    check("prio_drop", 32'(drop_cnt), 32'd1);

    // async reset at fill cycle 30
    for (int a = 30; a < 60; a++)
      step(0, 1, 8'(a), 8'($urandom), 8'd0, 8'd0);
    done_cnt = 0;
    step(1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 1; k <= 30; k++) idle();
    #2 rst_n = 1'b0;
    #1;
    left = 0; m_done = 0; m_drop = 0;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
`ifdef DMEM_FILL_RDREG_EN
    check("arst_rd0", 32'(rdata0), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 60; a++) step(0, 0, 8'd0, 8'd0, 8'(a), 8'(59 - a));
    check("arst_no_done", 32'(done_cnt), 32'd0);

    // random traffic
    for (int k = 0; k < 400; k++)
      step(($urandom_range(39) == 0), 1'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom));
    run_out();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
